// File: rtl/imm_pack_encoder.sv
// rtl/imm_pack_encoder.sv - two-stage immediate packer for instruction generation
//
// Purpose:
//   Inserts a 32-bit immediate into the immediate fields of a base instruction
//   word according to an immediate-type code (I/S/B/J/U). All other fields of
//   the base word pass through unchanged. Range, alignment and type problems
//   are flagged alongside the result. The flags never stall the pipe.
//   Saturating counters track completed output handshakes and errored ones.
//
// Ports:
//   clk, rst             rising-edge clock, synchronous active-high reset
//   in_valid/in_ready    request handshake (in_ready = pipeline can advance)
//   immsrc[2:0]          000 I, 001 S, 010 B, 011 J, 100 U, others invalid
//   imm[31:0]            immediate to encode
//   base[31:0]           instruction word providing the non-immediate fields
//   out_valid/out_ready  result handshake
//   instr[31:0]          packed instruction word
//   range_err            immediate not representable for immsrc
//   align_err            B/J immediate with imm[0]=1
//   type_err             immsrc is 101-111
//   enc_count[CNT_W-1:0] completed output handshakes, saturating
//   err_count[CNT_W-1:0] completed output handshakes carrying any flag, saturating

module imm_pack_encoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       immsrc,
  input  logic [31:0]      imm,
  input  logic [31:0]      base,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      instr,
  output logic             range_err,
  output logic             align_err,
  output logic             type_err,
  output logic [CNT_W-1:0] enc_count,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  // Stage 1: captured request
  logic        s1_valid_q;
  logic [2:0]  s1_src_q;
  logic [31:0] s1_imm_q;
  logic [31:0] s1_base_q;

  // Stage 2: packed result and flags
  logic        s2_valid_q;
  logic [31:0] instr_q;
  logic        range_q;
  logic        align_q;
  logic        type_q;

  logic [CNT_W-1:0] enc_q;
  logic [CNT_W-1:0] err_q;

  // Combinational results computed from stage 1
  logic [31:0] instr_d;
  logic        range_d;
  logic        align_d;
  logic        type_d;

  logic advance;
  logic out_fire;
  logic any_err;

  // Both stages move together; a stalled output freezes the whole pipe.
  assign advance  = !s2_valid_q || out_ready;
  assign in_ready = advance;
  assign out_fire = s2_valid_q && out_ready;
  assign any_err  = range_q || align_q || type_q;

  // A field is representable when all bits from the field's sign position
  // upward are copies of one another.
  function automatic logic all_eq(input logic [31:0] v, input int lo);
    logic ones;
    logic zeros;
    ones  = 1'b1;
    zeros = 1'b1;
    for (int i = 0; i < 32; i++) begin
      if (i >= lo) begin
        ones  = ones & v[i];
        zeros = zeros & ~v[i];
      end
    end
    return ones | zeros;
  endfunction

  always_comb begin
    instr_d = s1_base_q;
    range_d = 1'b0;
    align_d = 1'b0;
    type_d  = 1'b0;
    case (s1_src_q)
      IMM_I: begin
        instr_d[31:20] = s1_imm_q[11:0];
        range_d        = !all_eq(s1_imm_q, 11);
      end
      IMM_S: begin
        instr_d[31:25] = s1_imm_q[11:5];
        instr_d[11:7]  = s1_imm_q[4:0];
        range_d        = !all_eq(s1_imm_q, 11);
      end
      IMM_B: begin
        instr_d[31]    = s1_imm_q[12];
        instr_d[7]     = s1_imm_q[11];
        instr_d[30:25] = s1_imm_q[10:5];
        instr_d[11:8]  = s1_imm_q[4:1];
        range_d        = !all_eq(s1_imm_q, 12);
        align_d        = s1_imm_q[0];
      end
      IMM_J: begin
        instr_d[31]    = s1_imm_q[20];
        instr_d[30:21] = s1_imm_q[10:1];
        instr_d[20]    = s1_imm_q[11];
        instr_d[19:12] = s1_imm_q[19:12];
        range_d        = !all_eq(s1_imm_q, 20);
        align_d        = s1_imm_q[0];
      end
      IMM_U: begin
        instr_d[31:12] = s1_imm_q[31:12];
        range_d        = (s1_imm_q[11:0] != 12'h000);
      end
      default: begin
        type_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_src_q   <= 3'b000;
      s1_imm_q   <= 32'h0;
      s1_base_q  <= 32'h0;
      s2_valid_q <= 1'b0;
      instr_q    <= 32'h0;
      range_q    <= 1'b0;
      align_q    <= 1'b0;
      type_q     <= 1'b0;
    end else if (advance) begin
      s1_valid_q <= in_valid;
      s1_src_q   <= immsrc;
      s1_imm_q   <= imm;
      s1_base_q  <= base;
      s2_valid_q <= s1_valid_q;
      instr_q    <= instr_d;
      range_q    <= range_d;
      align_q    <= align_d;
      type_q     <= type_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      enc_q <= '0;
      err_q <= '0;
    end else if (out_fire) begin
      if (enc_q != {CNT_W{1'b1}}) begin
        enc_q <= enc_q + 1'b1;
      end
      if (any_err && (err_q != {CNT_W{1'b1}})) begin
        err_q <= err_q + 1'b1;
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign instr     = instr_q;
  assign range_err = range_q;
  assign align_err = align_q;
  assign type_err  = type_q;
  assign enc_count = enc_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_imm_pack_encoder.sv
// tb/tb_imm_pack_encoder.sv - scoreboard bench for imm_pack_encoder
//
// Purpose: drives directed and random requests, keeps expected results in a
// queue, and compares each emitted word, its flags and the counters.
// Ports: none (top-level bench).

module tb_imm_pack_encoder;

  localparam int CNT_W = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct {
    logic [31:0] instr;
    logic        r;
    logic        a;
    logic        t;
    logic [2:0]  src;
    logic [31:0] imm;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       immsrc;
  logic [31:0]      imm;
  logic [31:0]      base;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      instr;
  logic             range_err;
  logic             align_err;
  logic             type_err;
  logic [CNT_W-1:0] enc_count;
  logic [CNT_W-1:0] err_count;

  always #5 clk = ~clk;

  imm_pack_encoder #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .immsrc    (immsrc),
    .imm       (imm),
    .base      (base),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .instr     (instr),
    .range_err (range_err),
    .align_err (align_err),
    .type_err  (type_err),
    .enc_count (enc_count),
    .err_count (err_count)
  );

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t sb[$];
  int   enc_exp  = 0;
  int   err_exp  = 0;
  bit   mon_en   = 1'b0;
  bit   sweep_done;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic fits(input logic [31:0] v, input int lo);
    logic [31:0] sx;
    sx = $signed(v << (31 - lo)) >>> (31 - lo);
    return sx == v;
  endfunction

  function automatic exp_t model(input logic [2:0] src, input logic [31:0] im, input logic [31:0] bs);
    exp_t e;
    e.instr = bs; e.r = 1'b0; e.a = 1'b0; e.t = 1'b0; e.src = src; e.imm = im;
    case (src)
      3'd0: begin e.instr = {im[11:0], bs[19:0]}; e.r = !fits(im, 11); end
      3'd1: begin e.instr = {im[11:5], bs[24:12], im[4:0], bs[6:0]}; e.r = !fits(im, 11); end
      3'd2: begin
        e.instr = {im[12], im[10:5], bs[24:12], im[4:1], im[11], bs[6:0]};
        e.r = !fits(im, 12); e.a = im[0];
      end
      3'd3: begin
        e.instr = {im[20], im[10:1], im[11], im[19:12], bs[11:0]};
        e.r = !fits(im, 20); e.a = im[0];
      end
      3'd4: begin e.instr = {im[31:12], bs[11:0]}; e.r = (im[11:0] != 0); end
      default: e.t = 1'b1;
    endcase
    return e;
  endfunction

  function automatic exp_t mkx(input logic [31:0] ins, input logic r, input logic a, input logic t,
                               input logic [2:0] src, input logic [31:0] im);
    exp_t e;
    e.instr = ins; e.r = r; e.a = a; e.t = t; e.src = src; e.imm = im;
    return e;
  endfunction

  // Immediate extender used to confirm the round trip on clean results.
  function automatic logic [31:0] extend(input logic [31:0] w, input logic [2:0] src);
    case (src)
      3'd0:    return {{20{w[31]}}, w[31:20]};
      3'd1:    return {{20{w[31]}}, w[31:25], w[11:7]};
      3'd2:    return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      3'd3:    return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      default: return {w[31:12], 12'h000};
    endcase
  endfunction

  always @(negedge clk) begin
    exp_t e;
    logic e_err;
    if (mon_en) begin
      if (rst) begin
        sb.delete();
        enc_exp = 0;
        err_exp = 0;
      end else begin
        chk("enc_count", 32'(enc_count), enc_exp);
        chk("err_count", 32'(err_count), err_exp);
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            chk("spurious_out", 32'(out_valid), 32'd0);
            e_err = range_err | align_err | type_err;
          end else begin
            e = sb.pop_front();
            chk("instr", instr, e.instr);
            chk("range_err", 32'(range_err), 32'(e.r));
            chk("align_err", 32'(align_err), 32'(e.a));
            chk("type_err", 32'(type_err), 32'(e.t));
            if (!e.r && !e.a && !e.t) chk("roundtrip", extend(instr, e.src), e.imm);
            e_err = e.r | e.a | e.t;
          end
          if (enc_exp != CNT_MAX) enc_exp++;
          if (e_err && err_exp != CNT_MAX) err_exp++;
        end
      end
    end
  end

  task automatic send(input logic [2:0] src, input logic [31:0] im, input logic [31:0] bs, input exp_t e);
    in_valid = 1'b1; immsrc = src; imm = im; base = bs;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready && !rst) begin
        sb.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    chk("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic send_m(input logic [2:0] src, input logic [31:0] im, input logic [31:0] bs);
    send(src, im, bs, model(src, im, bs));
  endtask

  task automatic drain();
    for (int k = 0; k < 300; k++) begin
      @(posedge clk); #1;
      if (sb.size() == 0) return;
    end
    chk("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  function automatic logic [31:0] rand_legal(input logic [2:0] src);
    logic [31:0] r;
    r = $urandom;
    case (src)
      3'd0, 3'd1: return {{20{r[11]}}, r[11:0]};
      3'd2:       return {{19{r[12]}}, r[12:1], 1'b0};
      3'd3:       return {{11{r[20]}}, r[20:1], 1'b0};
      default:    return {r[31:12], 12'h000};
    endcase
  endfunction

  initial begin
    logic [31:0] held;
    logic [2:0]  s;
    rst = 1'b1; in_valid = 1'b0; immsrc = 3'd0; imm = 32'h0; base = 32'h0; out_ready = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_flags", {29'd0, range_err, align_err, type_err}, 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed vectors with fixed expectations
    send(3'd0, 32'hFFFF_FFFF, 32'h0000_0013, mkx(32'hFFF0_0013, 0, 0, 0, 3'd0, 32'hFFFF_FFFF));
    drain();
    chk("t1_enc_count", 32'(enc_count), 32'd1);
    send(3'd2, 32'hFFFF_F000, 32'h0000_0063, mkx(32'h8000_0063, 0, 0, 0, 3'd2, 32'hFFFF_F000));
    send(3'd3, 32'h0000_0800, 32'h0000_006F, mkx(32'h0010_006F, 0, 0, 0, 3'd3, 32'h0000_0800));
    send(3'd0, 32'h0000_0800, 32'h0000_0013, mkx(32'h8000_0013, 1, 0, 0, 3'd0, 32'h0000_0800));
    send(3'd2, 32'h0000_0003, 32'h0000_0063, mkx(32'h0000_0163, 0, 1, 0, 3'd2, 32'h0000_0003));
    send(3'd7, 32'hDEAD_BEEF, 32'h1234_5678, mkx(32'h1234_5678, 0, 0, 1, 3'd7, 32'hDEAD_BEEF));
    send(3'd4, 32'h0000_0001, 32'h0000_0037, mkx(32'h0000_0037, 1, 0, 0, 3'd4, 32'h0000_0001));
    send(3'd3, 32'h0010_0000, 32'h0000_006F, mkx(32'h8000_006F, 1, 0, 0, 3'd3, 32'h0010_0000));
    drain();
    chk("dir_err_count", 32'(err_count), 32'd5);

    // Backpressure: 4 back-to-back requests, stall output 3 cycles
    fork
      begin
        for (int i = 0; i < 4; i++) send_m(3'd1, 32'(i * 37 - 60), 32'h0000_2023 + 32'(i << 15));
      end
      begin
        for (int k = 0; k < 50; k++) begin
          @(posedge clk); #1;
          if (out_valid) break;
        end
        out_ready = 1'b0;
        held = instr;
        for (int c = 0; c < 3; c++) begin
          @(negedge clk);
          chk("stall_in_ready", 32'(in_ready), 32'd0);
          chk("stall_out_valid", 32'(out_valid), 32'd1);
          chk("stall_instr", instr, held);
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with two items in flight
    send_m(3'd0, 32'h0000_0123, 32'h0000_0093);
    send_m(3'd0, 32'h0000_0456, 32'h0000_0113);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("post_rst_out_valid", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
    end
    chk("post_rst_enc", 32'(enc_count), 32'd0);
    chk("post_rst_err", 32'(err_count), 32'd0);
    send(3'd0, 32'h0000_07FF, 32'h0000_0013, mkx(32'h7FF0_0013, 0, 0, 0, 3'd0, 32'h0000_07FF));
    drain();
    chk("post_rst_first_enc", 32'(enc_count), 32'd1);

    // Random round-trip sweep with random backpressure
    sweep_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          s = 3'($urandom_range(0, 4));
          send_m(s, rand_legal(s), $urandom);
        end
        sweep_done = 1'b1;
      end
      begin
        for (int k = 0; k < 2000 && !sweep_done; k++) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    out_ready = 1'b1;
    drain();

    // Counter saturation: 20 errored handshakes from reset
    do_reset();
    for (int i = 0; i < 20; i++) begin
      s = 3'(5 + (i % 3));
      send_m(s, $urandom, $urandom);
    end
    drain();
    @(negedge clk);
    chk("sat_enc_count", 32'(enc_count), 32'd15);
    chk("sat_err_count", 32'(err_count), 32'd15);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
